// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants and FSM state type for the text console
//
// Purpose: screen geometry, control-character codes and the controller state
//          enum used by text_console_ctrl and text_cursor.
// Ports:   none (package).

package vga_text_pkg;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_SCROLL = 2'd3
  } state_t;

endpackage

// File: rtl/text_cursor.sv
// rtl/text_cursor.sv - cursor and ring-buffer top_row counters with address generation
//
// Purpose: holds the logical cursor (x, y) and the physical row shown as screen
//          row 0 (top_row); maps the cursor to a physical buffer address.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   home               cursor to (0,0), top_row to 0
//   cr                 x to 0
//   nl                 x to 0 and advance one line (rotates top_row at bottom)
//   inc                x+1, wrapping to a new line after the last column
//   bs                 step back one cell (no-op at (0,0))
//   x, y, top_row      current cursor and ring-buffer origin
//   addr               physical address of the cursor cell
//   back_addr          physical address of the cell a backspace moves to
//   scroll_base        first address of the row that becomes the bottom row on a scroll
//   at_bottom, at_last_col, at_origin   cursor position flags

module text_cursor
  import vga_text_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        home,
  input  logic        cr,
  input  logic        nl,
  input  logic        inc,
  input  logic        bs,
  output logic [6:0]  x,
  output logic [4:0]  y,
  output logic [4:0]  top_row,
  output logic [11:0] addr,
  output logic [11:0] back_addr,
  output logic [11:0] scroll_base,
  output logic        at_bottom,
  output logic        at_last_col,
  output logic        at_origin
);

  logic [5:0] prow_sum;
  logic [4:0] prow;
  logic       wrap;

  // y and top_row are both < ROWS, so one conditional subtract is a full mod.
  assign prow_sum = {1'b0, y} + {1'b0, top_row};
  assign prow     = (prow_sum >= 6'(ROWS)) ? 5'(prow_sum - 6'(ROWS)) : prow_sum[4:0];

  assign addr = 12'(prow) * 12'(COLS) + 12'(x);

  // Stepping back from column 0 lands on the last column of the previous
  // physical row, which is simply addr-1 except when wrapping below row 0.
  assign back_addr = (addr == 12'd0) ? 12'(CELLS - 1) : addr - 12'd1;

  // After rotation the bottom screen row maps to the old top_row.
  assign scroll_base = 12'(top_row) * 12'(COLS);

  assign at_bottom   = (y == 5'(ROWS - 1));
  assign at_last_col = (x == 7'(COLS - 1));
  assign at_origin   = (x == 7'd0) && (y == 5'd0);

  assign wrap = nl | (inc & at_last_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= 7'd0;
      y       <= 5'd0;
      top_row <= 5'd0;
    end else if (home) begin
      x       <= 7'd0;
      y       <= 5'd0;
      top_row <= 5'd0;
    end else if (wrap) begin
      x <= 7'd0;
      if (at_bottom) begin
        top_row <= (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 5'd1;
      end else begin
        y <= y + 5'd1;
      end
    end else if (inc) begin
      x <= x + 7'd1;
    end else if (cr) begin
      x <= 7'd0;
    end else if (bs) begin
      if (x != 7'd0) begin
        x <= x - 7'd1;
      end else if (y != 5'd0) begin
        x <= 7'(COLS - 1);
        y <= y - 5'd1;
      end
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - character-stream controller for the 70x30 text buffer
//
// Purpose: accepts characters over a valid/ready handshake, interprets CR/LF/BS/FF,
//          writes printable characters into the screen buffer and runs the
//          full-clear and single-row scroll fill sequences.
// Ports:
//   CLOCK_50              system clock
//   rst_n                 asynchronous active-low reset
//   char_valid/char_data  input character stream
//   char_ready            high in IDLE
//   wraddress/data/wren   registered buffer write port
//   cursor_x/cursor_y     logical cursor
//   top_row               physical row displayed as screen row 0
//   busy                  clear or scroll in progress

module text_console_ctrl
  import vga_text_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [11:0] wraddress,
  output logic [7:0]  data,
  output logic        wren,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [4:0]  top_row,
  output logic        busy
);

  state_t      state, state_next;
  logic [11:0] fill, fill_next;
  logic [11:0] fill_last;
  logic [11:0] addr_next;
  logic [7:0]  data_next;
  logic        wren_next;

  logic [11:0] cur_addr, back_addr, scroll_base;
  logic        at_bottom, at_last_col, at_origin;

  logic accept, is_print, is_cr, is_lf, is_bs, is_ff;
  logic wrote_print, scroll_start, fill_done;
  logic cmd_home, cmd_cr, cmd_nl, cmd_inc, cmd_bs;

  assign accept   = char_valid & (state == ST_IDLE);
  assign is_print = (char_data >= ASCII_SPACE);
  assign is_cr    = (char_data == ASCII_CR);
  assign is_lf    = (char_data == ASCII_LF);
  assign is_bs    = (char_data == ASCII_BS);
  assign is_ff    = (char_data == ASCII_FF);

  // In WRITE the data register holds the character: nonzero means a printable
  // write (cursor advances), zero means a backspace erase (cursor already moved).
  assign wrote_print  = (state == ST_WRITE) && (data != 8'd0);
  assign scroll_start = (accept & is_lf & at_bottom) |
                        (wrote_print & at_last_col & at_bottom);

  assign fill_last = (state == ST_CLEAR) ? 12'(CELLS - 1) : 12'(COLS - 1);
  // wren low inside CLEAR only happens in the first cycle after reset.
  assign fill_done = wren && (fill == fill_last);

  assign char_ready = (state == ST_IDLE);
  assign busy       = (state == ST_CLEAR) || (state == ST_SCROLL);

  assign cmd_home = accept & is_ff;
  assign cmd_cr   = accept & is_cr;
  assign cmd_nl   = accept & is_lf;
  assign cmd_bs   = accept & is_bs;
  assign cmd_inc  = wrote_print;

  text_cursor u_cursor (
    .clk         (CLOCK_50),
    .rst_n       (rst_n),
    .home        (cmd_home),
    .cr          (cmd_cr),
    .nl          (cmd_nl),
    .inc         (cmd_inc),
    .bs          (cmd_bs),
    .x           (cursor_x),
    .y           (cursor_y),
    .top_row     (top_row),
    .addr        (cur_addr),
    .back_addr   (back_addr),
    .scroll_base (scroll_base),
    .at_bottom   (at_bottom),
    .at_last_col (at_last_col),
    .at_origin   (at_origin)
  );

  // State register
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_print)                state_next = ST_WRITE;
          else if (is_lf && at_bottom) state_next = ST_SCROLL;
          else if (is_bs && !at_origin) state_next = ST_WRITE;
          else if (is_ff)              state_next = ST_CLEAR;
        end
      end
      ST_WRITE:  state_next = scroll_start ? ST_SCROLL : ST_IDLE;
      ST_CLEAR,
      ST_SCROLL: if (fill_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Write-port next values: registered so they are valid during the state they belong to.
  always_comb begin
    wren_next = 1'b0;
    addr_next = wraddress;
    data_next = data;
    fill_next = fill;
    if (scroll_start) begin
      wren_next = 1'b1;
      addr_next = scroll_base;
      data_next = 8'd0;
      fill_next = 12'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_print) begin
              wren_next = 1'b1;
              addr_next = cur_addr;
              data_next = char_data;
            end else if (is_bs && !at_origin) begin
              wren_next = 1'b1;
              addr_next = back_addr;
              data_next = 8'd0;
            end else if (is_ff) begin
              wren_next = 1'b1;
              addr_next = 12'd0;
              data_next = 8'd0;
              fill_next = 12'd0;
            end
          end
        end
        ST_CLEAR,
        ST_SCROLL: begin
          data_next = 8'd0;
          if (!fill_done) begin
            wren_next = 1'b1;
            addr_next = wren ? wraddress + 12'd1 : 12'd0;
            fill_next = wren ? fill + 12'd1 : 12'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wren      <= 1'b0;
      wraddress <= 12'd0;
      data      <= 8'd0;
      fill      <= 12'd0;
    end else begin
      wren      <= wren_next;
      wraddress <= addr_next;
      data      <= data_next;
      fill      <= fill_next;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb/tb_text_console_ctrl.sv - self-checking bench for text_console_ctrl

module tb_text_console_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'd0;
  logic        char_ready;
  logic [11:0] wraddress;
  logic [7:0]  data;
  logic        wren;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [4:0]  top_row;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  text_console_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wraddress  (wraddress),
    .data       (data),
    .wren       (wren),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .top_row    (top_row),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every buffer write is compared against the head of the expected-write queue.
  always @(negedge clk) begin : write_monitor
    logic [19:0] e;
    if (mon_en && rst_n && wren) begin
      e = 20'hFFFFF;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      assert ({wraddress, data} === e) else begin
        bad++;
        $error("FAIL write: got addr=%0d data=%0h expected addr=%0d data=%0h",
               wraddress, data, e[19:8], e[7:0]);
      end
    end
  end

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back({12'(a), d});
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    while (!char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $error("FAIL send_timeout: got ready=0 expected ready=1 char=%0h", c);
    end
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !char_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 5000), 32'd1);
  endtask

  initial begin
    // Reset state and power-on clear
    repeat (3) @(negedge clk);
    chk("rst_wren", wren, 0);
    chk("rst_addr", wraddress, 0);
    chk("rst_data", data, 0);
    chk("rst_x", cursor_x, 0);
    chk("rst_y", cursor_y, 0);
    chk("rst_top", top_row, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    for (int a = 0; a < 2100; a++) push(a, 8'h00);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    drain("clr");
    chk("clr_ready", char_ready, 1);
    chk("clr_busy", busy, 0);

    // 'A' at (0,0): write one cycle after acceptance
    push(0, 8'h41);
    send(8'h41);
    @(negedge clk);
    chk("a_wren", wren, 1);
    chk("a_addr", wraddress, 0);
    chk("a_data", data, 8'h41);
    drain("a");
    chk("a_x", cursor_x, 1);
    chk("a_y", cursor_y, 0);

    // FF, then 71 'B' sent at once (first one held while clearing)
    for (int a = 0; a < 2100; a++) push(a, 8'h00);
    for (int i = 0; i < 71; i++) push(i, 8'h42);
    send(8'h0C);
    for (int i = 0; i < 71; i++) send(8'h42);
    drain("b");
    chk("b_x", cursor_x, 1);
    chk("b_y", cursor_y, 1);
    chk("b_top", top_row, 0);

    // Move to the bottom row, then LF scrolls
    send(8'h0D);
    for (int i = 0; i < 28; i++) send(8'h0A);
    chk("bot_x", cursor_x, 0);
    chk("bot_y", cursor_y, 29);
    chk("bot_top", top_row, 0);
    for (int a = 0; a < 70; a++) push(a, 8'h00);
    send(8'h0A);
    begin
      int nb = 0;
      @(negedge clk);
      while (busy && nb < 200) begin
        nb++;
        @(negedge clk);
      end
      chk("scroll_busy_cycles", nb, 70);
    end
    drain("lf");
    chk("lf_top", top_row, 1);
    chk("lf_x", cursor_x, 0);
    chk("lf_y", cursor_y, 29);

    // Fill bottom row (physical row 0) and wrap -> scroll of physical row 1
    for (int i = 0; i < 69; i++) push(i, 8'h43);
    push(69, 8'h44);
    for (int a = 70; a < 140; a++) push(a, 8'h00);
    for (int i = 0; i < 69; i++) send(8'h43);
    send(8'h44);
    drain("wrap");
    chk("wrap_top", top_row, 2);
    chk("wrap_x", cursor_x, 0);
    chk("wrap_y", cursor_y, 29);

    // BS across a row boundary with rotation: (0,29) -> (69,28), physical row 0
    push(69, 8'h00);
    send(8'h08);
    drain("bs_rot");
    chk("bs_rot_x", cursor_x, 69);
    chk("bs_rot_y", cursor_y, 28);

    // BS at (0,1) with top_row 0
    for (int a = 0; a < 2100; a++) push(a, 8'h00);
    send(8'h0C);
    send(8'h0A);
    push(69, 8'h00);
    send(8'h08);
    drain("bs");
    chk("bs_x", cursor_x, 69);
    chk("bs_y", cursor_y, 0);

    // BS at (0,0): no move, no write; other control code ignored
    send(8'h0D);
    send(8'h08);
    repeat (3) @(negedge clk);
    chk("bs0_x", cursor_x, 0);
    chk("bs0_y", cursor_y, 0);
    chk("bs0_noq", exp_q.size(), 0);
    send(8'h01);
    @(negedge clk);
    chk("ign_ready", char_ready, 1);
    chk("ign_wren", wren, 0);
    chk("ign_x", cursor_x, 0);

    // Asynchronous reset in the middle of a scroll
    for (int i = 0; i < 29; i++) send(8'h0A);
    mon_en = 1'b0;
    send(8'h0A);
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wren", wren, 0);
    chk("arst_addr", wraddress, 0);
    chk("arst_top", top_row, 0);
    chk("arst_y", cursor_y, 0);
    chk("arst_ready", char_ready, 0);
    exp_q.delete();
    for (int a = 0; a < 2100; a++) push(a, 8'h00);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_ready", char_ready, 0);
    drain("reclr");
    chk("reclr_ready", char_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
